wd_console_uart: RTL and testbench
==================================

Name: wd_console_uart

Overview:
- Downstream console stage for the Sigma CPU's WD (write direct) character output.
- Accepts 8-bit characters through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each character as UART 8N1 on a single tx pin, so simulation `$write` console output has a synthesizable hardware equivalent.

Parameters:
- CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 16, character FIFO depth; power of two.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- char_valid  input  1  CPU presents a character this cycle.
- char_data  input  [0:7]  character; bit 0 MSB, bit 7 LSB; CPU drives {1'b0, rr[r][25:31]}.
- char_ready  output  1  FIFO can accept; equals (fifo_count != FIFO_DEPTH).
- overflow_clear  input  1  clears sticky overflow flag.
- tx  output  1  UART serial out, idle high, registered.
- tx_busy  output  1  high while a frame is in progress (state != IDLE).
- fifo_count  output  [0:FIFO_AW]  characters currently queued.
- overflow  output  1  sticky; a character was offered while char_ready=0.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: sampled only on posedge clock with reset==0.
- Reset values: tx=1, tx_busy=0, fifo_count=0, overflow=0, char_ready=1. Read/write pointers=0, baud counter=0, bit counter=0, state=IDLE.
- Reset mid-frame: at that edge tx returns to 1, the FIFO is flushed, and the frame is abandoned. No further bits are sent.
- Enqueue: on an edge with char_valid & char_ready, write char_data at wptr and increment wptr modulo FIFO_DEPTH.
- Drop on full: char_valid & ~char_ready discards the character and sets overflow=1.
- Full with a same-cycle pop: char_ready is still 0, so no enqueue occurs.
- overflow_clear sets overflow=0. If an overflow event and overflow_clear occur together, set wins.
- fifo_count: +1 on enqueue only, -1 on pop only, unchanged when both occur. Never exceeds FIFO_DEPTH and never underflows.
- TX FSM states are IDLE, START, DATA, STOP, driven by a baud counter (0..CLKS_PER_BIT-1) and a bit counter (0..7).
- IDLE: if fifo_count != 0, pop the head into an 8-bit shift register, set tx<=0, reset the baud counter and go to START. Otherwise hold tx=1.
- START: hold tx=0 for CLKS_PER_BIT clocks. On the last clock, load tx with shift bit 7 (LSB) and go to DATA.
- DATA: each bit lasts CLKS_PER_BIT clocks, sent LSB first (char_data[7] first, char_data[0] last).
  - After the 8th bit, tx<=1 and go to STOP.
- STOP: hold tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
- Frame length is 10*CLKS_PER_BIT clocks. Back-to-back frames have exactly one IDLE clock between them (start-bit spacing 10*CLKS_PER_BIT+1).
- Latency: a character enqueued into an empty FIFO at edge N drives tx low after edge N+1.
- Pointers wrap modulo FIFO_DEPTH. Characters are transmitted strictly in acceptance order.

Optional Feature:
- Macro: CONSOLE_CRLF_EN.
- Defined: when IDLE pops 0x0A, the block first sends a 0x0D frame.
  - A pending_lf flag then makes STOP go directly to START with 0x0A, with no IDLE clock and no second pop.
  - pending_lf clears on reset.
  - fifo_count decrements once for the LF.
- Undefined: bytes are sent verbatim and pending_lf logic is absent.

Test Plan:
- CLKS_PER_BIT=4: accept 0x41 at edge N -> tx low after N+1 for 4 clocks, then data bits 1,0,0,0,0,0,1,0 at 4 clocks each, stop high 4 clocks; tx_busy high for 40 clocks, then 0.
- FIFO_DEPTH=16, 18 consecutive char_valid cycles (0x30..0x41) from idle -> first 17 accepted, 18th (0x41) dropped; char_ready=0 and fifo_count=16 after the 17th accept; overflow=1; tx emits 0x30..0x40 in order.
- overflow=1: pulse overflow_clear alone -> overflow=0. Repeat with overflow_clear coinciding with a drop on a full FIFO -> overflow stays 1.
- Two chars 0x55, 0xAA queued back-to-back, CLKS_PER_BIT=4 -> second start bit falls exactly 41 clocks after the first.
- Assert reset=0 for one clock during DATA bit 3 with 5 chars queued -> tx=1, fifo_count=0, tx_busy=0 after that edge; tx stays high for 100 clocks.
- With CONSOLE_CRLF_EN, send 0x0A at CLKS_PER_BIT=4 -> frames 0x0D then 0x0A with no idle clock between (80 clocks busy); fifo_count 1->0. Without the macro -> single 0x0A frame (40 clocks).

Source files
------------

// File: rtl/wd_console_uart.sv
`default_nettype none
// ============================================================================
// Module   : wd_console_uart
// Brief    : Console output stage for the Sigma CPU WD character path.
//            Characters arrive over a valid/ready handshake, are queued in a
//            small FIFO and leave as UART 8N1 frames on a registered tx pin.
// Options  : `define CONSOLE_CRLF_EN to expand each LF (0x0A) into CR+LF.
// Revision : 1.0 - initial release
// ============================================================================
module wd_console_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [0:7]       char_data,
  output logic             char_ready,
  input  logic             overflow_clear,
  output logic             tx,
  output logic             tx_busy,
  output logic [0:FIFO_AW] fifo_count,
  output logic             overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE   = BAUD_W'(1);
  localparam logic [0:FIFO_AW]   COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [0:FIFO_AW]   COUNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [2:0]         BIT_LAST   = 3'd7;
  localparam logic [2:0]         BIT_ONE    = 3'd1;
`ifdef CONSOLE_CRLF_EN
  localparam logic [0:7]         CHAR_LF    = 8'h0A;
  localparam logic [0:7]         CHAR_CR    = 8'h0D;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Character storage and queue bookkeeping
  logic [0:7]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [0:FIFO_AW]   count;
  logic [0:7]         head;
  logic               push;
  logic               pop;
  logic               drop;
  logic               overflow_reg;

  // Transmitter state; shreg index 7 is the next bit to go out (LSB first)
  state_t             state;
  state_t             state_next;
  logic [0:7]         shreg;
  logic [0:7]         shreg_next;
  logic [BAUD_W-1:0]  baud;
  logic [BAUD_W-1:0]  baud_next;
  logic [2:0]         bitcnt;
  logic [2:0]         bitcnt_next;
  logic               tx_reg;
  logic               tx_next;
  logic               baud_done;
`ifdef CONSOLE_CRLF_EN
  // Set while a CR is on the wire and its LF still has to follow
  logic               pending_lf;
  logic               pending_next;
`endif

  // A full FIFO refuses characters even when the transmitter pops on the
  // same edge; the slot only becomes visible one cycle later.
  assign char_ready = (count != COUNT_FULL);
  assign push       = char_valid & char_ready;
  assign drop       = char_valid & ~char_ready;
  assign head       = mem[rptr];
  assign baud_done  = (baud == BAUD_LAST);

  assign fifo_count = count;
  assign overflow   = overflow_reg;
  assign tx         = tx_reg;
  assign tx_busy    = (state != IDLE);

  // Character storage: written on every accepted character, never reset
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wptr] <= char_data;
    end
  end

  // Queue pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      // A drop on the same edge as a clear keeps the flag set
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (overflow_clear) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Transmitter registers; reset abandons any frame and idles the line high
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      baud       <= '0;
      bitcnt     <= '0;
      tx_reg     <= 1'b1;
`ifdef CONSOLE_CRLF_EN
      pending_lf <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      baud       <= baud_next;
      bitcnt     <= bitcnt_next;
      tx_reg     <= tx_next;
`ifdef CONSOLE_CRLF_EN
      pending_lf <= pending_next;
`endif
    end
  end

  // Frame sequencing: start bit, eight data bits LSB first, stop bit
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    baud_next   = baud;
    bitcnt_next = bitcnt;
    tx_next     = tx_reg;
    pop         = 1'b0;
`ifdef CONSOLE_CRLF_EN
    pending_next = pending_lf;
`endif
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (count != '0) begin
          pop        = 1'b1;
          shreg_next = head;
          tx_next    = 1'b0;
          baud_next  = '0;
          state_next = START;
`ifdef CONSOLE_CRLF_EN
          // Send CR first; the LF itself is replayed from STOP
          if (head == CHAR_LF) begin
            shreg_next   = CHAR_CR;
            pending_next = 1'b1;
          end
`endif
        end
      end

      START: begin
        if (baud_done) begin
          tx_next     = shreg[7];
          shreg_next  = {1'b0, shreg[0:6]};
          baud_next   = '0;
          bitcnt_next = '0;
          state_next  = DATA;
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bitcnt == BIT_LAST) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next     = shreg[7];
            shreg_next  = {1'b0, shreg[0:6]};
            bitcnt_next = bitcnt + BIT_ONE;
          end
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
`ifdef CONSOLE_CRLF_EN
          // Chain straight into the LF frame without an idle clock
          if (pending_lf) begin
            shreg_next   = CHAR_LF;
            tx_next      = 1'b0;
            pending_next = 1'b0;
            state_next   = START;
          end
`endif
        end else begin
          baud_next = baud + BAUD_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wd_console_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_wd_console_uart
// Brief    : Self-checking bench for wd_console_uart at CLKS_PER_BIT=4.
//            Expected bytes live in a queue; a UART receiver decodes tx.
// Options  : honours `define CONSOLE_CRLF_EN for the LF expansion cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wd_console_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef CONSOLE_CRLF_EN
  localparam int LF_BUSY = 20 * CPB;
`else
  localparam int LF_BUSY = 10 * CPB;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          char_valid = 1'b0;
  logic [0:7]    char_data = '0;
  logic          char_ready;
  logic          overflow_clear = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic [0:AW]   fifo_count;
  logic          overflow;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic          mon_en = 1'b1;
  logic [7:0]    exp_q[$];

  typedef struct {
    logic [7:0] ch;
    logic [0:9] frame;   // line levels in time order: start, d0..d7, stop
  } vec_t;
  vec_t tbl [6];

  wd_console_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .char_valid     (char_valid),
    .char_data      (char_data),
    .char_ready     (char_ready),
    .overflow_clear (overflow_clear),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at time %0t", name, $time);
  endtask

  // What the receiver should see for one accepted character
  task automatic push_exp(input logic [7:0] c);
`ifdef CONSOLE_CRLF_EN
    if (c == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(c);
  endtask

  // Present one character for exactly one edge
  task automatic send(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (fifo_count == 0 && !tx_busy) break;
      tick();
    end
    if (i >= 2000) bound_fail("wait_idle");
  endtask

  // UART receiver: samples mid-bit and checks against the expected queue
  initial begin : monitor
    logic [7:0] rx;
    forever begin
      tick();
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) tick();
        check("start_bit", 32'(tx), 32'(0));
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) tick();
          rx[i] = tx;
        end
        repeat (CPB) tick();
        check("stop_bit", 32'(tx), 32'(1));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rx_unexpected: got %02h, expected no frame", rx);
        end else begin
          check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    int i;
    logic bad;

    tbl[0] = '{8'h41, 10'b0100000101};
    tbl[1] = '{8'h55, 10'b0101010101};
    tbl[2] = '{8'hAA, 10'b0010101011};
    tbl[3] = '{8'h00, 10'b0000000001};
    tbl[4] = '{8'hFF, 10'b0111111111};
    tbl[5] = '{8'h3C, 10'b0001111001};

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_tx",       32'(tx),         32'(1));
    check("rst_busy",     32'(tx_busy),    32'(0));
    check("rst_count",    32'(fifo_count), 32'(0));
    check("rst_overflow", 32'(overflow),   32'(0));
    check("rst_ready",    32'(char_ready), 32'(1));
    reset = 1'b1;
    tick();

    // Table: one frame per character, line checked every clock
    for (int t = 0; t < 6; t++) begin
      wait_idle();
      send(tbl[t].ch);
      push_exp(tbl[t].ch);
      check("tbl_count_after_accept", 32'(fifo_count), 32'(1));
      for (int k = 0; k < 10 * CPB; k++) begin
        tick();
        if (k == 0) check("tbl_count_after_pop", 32'(fifo_count), 32'(0));
        check("tbl_tx_bit", 32'(tx), 32'(tbl[t].frame[k / CPB]));
        check("tbl_busy", 32'(tx_busy), 32'(1));
      end
      tick();
      check("tbl_busy_end", 32'(tx_busy), 32'(0));
      check("tbl_tx_end",   32'(tx),      32'(1));
    end

    // Back-to-back frames: one idle clock between them
    wait_idle();
    send(8'h55);
    push_exp(8'h55);
    send(8'hAA);
    push_exp(8'hAA);
    check("b2b_first_start", 32'(tx), 32'(0));
    for (int j = 1; j <= 10 * CPB + 1; j++) begin
      tick();
      if (j == 10 * CPB - 1) check("b2b_stop_busy", 32'(tx_busy), 32'(1));
      if (j == 10 * CPB) begin
        check("b2b_idle_busy", 32'(tx_busy), 32'(0));
        check("b2b_idle_tx",   32'(tx),      32'(1));
      end
      if (j == 10 * CPB + 1) begin
        check("b2b_second_start", 32'(tx),      32'(0));
        check("b2b_second_busy",  32'(tx_busy), 32'(1));
      end
    end

    // Fill past capacity: 17 accepted, the 18th dropped
    wait_idle();
    for (int k = 0; k < 18; k++) begin
      char_valid = 1'b1;
      char_data  = 8'(8'h30 + k);
      tick();
      if (k <= 16) push_exp(8'(8'h30 + k));
      if (k == 16) begin
        check("full_ready", 32'(char_ready), 32'(0));
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        check("full_no_overflow_yet", 32'(overflow), 32'(0));
      end
    end
    char_valid = 1'b0;
    check("drop_overflow", 32'(overflow), 32'(1));
    check("drop_count",    32'(fifo_count), 32'(DEPTH));

    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("clear_alone", 32'(overflow), 32'(0));

    char_valid = 1'b1;
    char_data  = 8'h7E;
    overflow_clear = 1'b1;
    tick();
    char_valid = 1'b0;
    overflow_clear = 1'b0;
    check("clear_vs_drop", 32'(overflow), 32'(1));
    check("clear_vs_drop_count", 32'(fifo_count), 32'(DEPTH));

    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("clear_again", 32'(overflow), 32'(0));

    // Offer on the very edge the full FIFO pops: still refused
    for (i = 0; i < 100 && tx_busy; i++) tick();
    if (i >= 100) bound_fail("wait_frame_end");
    check("pop_edge_ready", 32'(char_ready), 32'(0));
    char_valid = 1'b1;
    char_data  = 8'h7F;
    tick();
    char_valid = 1'b0;
    check("pop_edge_count",    32'(fifo_count), 32'(DEPTH - 1));
    check("pop_edge_overflow", 32'(overflow),   32'(1));
    check("pop_edge_busy",     32'(tx_busy),    32'(1));
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;

    // Line feed: CR+LF pair when expansion is built in, else one frame
    wait_idle();
    send(8'h0A);
    push_exp(8'h0A);
    check("lf_count_accept", 32'(fifo_count), 32'(1));
    tick();
    check("lf_count_pop", 32'(fifo_count), 32'(0));
    cyc = 0;
    for (i = 0; i < 300 && tx_busy; i++) begin
      cyc++;
      tick();
      if (tx_busy) check("lf_count_stays", 32'(fifo_count), 32'(0));
    end
    if (i >= 300) bound_fail("lf_busy");
    check("lf_busy_cycles", 32'(cyc), 32'(LF_BUSY));

    // Reset during data bit 3 with characters queued
    wait_idle();
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) send(8'(8'h61 + k));
    repeat (4 * CPB + 1 - 4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_tx",    32'(tx),         32'(1));
    check("midrst_count", 32'(fifo_count), 32'(0));
    check("midrst_busy",  32'(tx_busy),    32'(0));
    check("midrst_ready", 32'(char_ready), 32'(1));
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet_100", 32'(bad), 32'(0));
    mon_en = 1'b1;

    // Random traffic, kept below capacity, checked by the receiver
    for (int n = 0; n < 60; n++) begin
      logic [7:0] c;
      for (i = 0; i < 2000 && exp_q.size() >= 10; i++) tick();
      if (i >= 2000) bound_fail("rand_backpressure");
      repeat ($urandom_range(0, 3)) tick();
      c = 8'($urandom_range(0, 255));
      check("rand_ready", 32'(char_ready), 32'(1));
      send(c);
      push_exp(c);
    end

    for (i = 0; i < 5000 && (exp_q.size() != 0 || tx_busy); i++) tick();
    if (i >= 5000) bound_fail("final_drain");
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_count",       32'(fifo_count),   32'(0));
    check("final_tx",          32'(tx),           32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
